shift_count_reg_pc: RTL and testbench

- Parametrised WIDTH-bit register: a multi-mode successor to the single-bit preset/clear flip-flop.
- Modes: hold, parallel load, shift, rotate, increment and decrement, all selected per cycle.
- Clear is asynchronous; preset is synchronous.
- Sits in datapaths that need a loadable shift/count register, e.g. ALU operand staging and loop counters.

---
 rtl/shift_count_reg_pc.sv | 87 ++++++++
 tb/tb_shift_count_reg_pc.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/shift_count_reg_pc.sv
// Multi-mode WIDTH-bit register: hold, load, shift, rotate, increment and
// decrement. C is an asynchronous clear. P is a synchronous preset.
// wrap pulses for one cycle after a count crosses the all-ones/zero boundary.
module shift_count_reg_pc #(
  parameter int              WIDTH      = 8,
  parameter logic [WIDTH-1:0] PRESET_VAL = {WIDTH{1'b1}}
) (
  input  logic             clk,
  input  logic             C,
  input  logic             P,
  input  logic             en,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] d,
  input  logic             sin_l,
  input  logic             sin_r,
  output logic [WIDTH-1:0] Q,
  output logic             sout_l,
  output logic             sout_r,
  output logic             zero,
  output logic             wrap
);

  // Mode encodings. All eight codes are defined, so there is no illegal mode.
  localparam logic [2:0] MODE_HOLD = 3'b000;
  localparam logic [2:0] MODE_LOAD = 3'b001;
  localparam logic [2:0] MODE_SHL  = 3'b010;
  localparam logic [2:0] MODE_SHR  = 3'b011;
  localparam logic [2:0] MODE_ROL  = 3'b100;
  localparam logic [2:0] MODE_ROR  = 3'b101;
  localparam logic [2:0] MODE_INC  = 3'b110;
  localparam logic [2:0] MODE_DEC  = 3'b111;

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] op_q;
  logic             op_wrap;

  // Result of the selected mode operation, used only when en=1 and P=0.
  always_comb begin
    op_q    = Q;
    op_wrap = 1'b0;
    case (mode)
      MODE_HOLD: op_q = Q;
      MODE_LOAD: op_q = d;
      MODE_SHL:  op_q = {Q[WIDTH-2:0], sin_l};
      MODE_SHR:  op_q = {sin_r, Q[WIDTH-1:1]};
      MODE_ROL:  op_q = {Q[WIDTH-2:0], Q[WIDTH-1]};
      MODE_ROR:  op_q = {Q[0], Q[WIDTH-1:1]};
      MODE_INC: begin
        op_q    = Q + ONE;
        op_wrap = &Q;
      end
      MODE_DEC: begin
        op_q    = Q - ONE;
        op_wrap = ~|Q;
      end
      default: begin
        op_q    = Q;
        op_wrap = 1'b0;
      end
    endcase
  end

  // Register update: clear beats preset, preset beats enable, otherwise hold.
  always_ff @(posedge clk or posedge C) begin
    if (C) begin
      Q    <= '0;
      wrap <= 1'b0;
    end else if (P) begin
      Q    <= PRESET_VAL;
      wrap <= 1'b0;
    end else if (en) begin
      Q    <= op_q;
      wrap <= op_wrap;
    end else begin
      wrap <= 1'b0;
    end
  end

  // Serial outputs and zero flag track Q in the same cycle.
  always_comb begin
    sout_l = Q[WIDTH-1];
    sout_r = Q[0];
    zero   = (Q == '0);
  end

endmodule

// File: tb/tb_shift_count_reg_pc.sv
// Directed bench for shift_count_reg_pc (WIDTH=8, PRESET_VAL=8'hFF).
module tb_shift_count_reg_pc;

  logic       clk;
  logic       C;
  logic       P;
  logic       en;
  logic [2:0] mode;
  logic [7:0] d;
  logic       sin_l;
  logic       sin_r;
  logic [7:0] Q;
  logic       sout_l;
  logic       sout_r;
  logic       zero;
  logic       wrap;

  int n_cmp = 0;
  int n_err = 0;

  shift_count_reg_pc #(.WIDTH(8), .PRESET_VAL(8'hFF)) dut (
    .clk    (clk),
    .C      (C),
    .P      (P),
    .en     (en),
    .mode   (mode),
    .d      (d),
    .sin_l  (sin_l),
    .sin_r  (sin_r),
    .Q      (Q),
    .sout_l (sout_l),
    .sout_r (sout_r),
    .zero   (zero),
    .wrap   (wrap)
  );

  // Clock: 10 ns period, rising edge at 5, 15, 25 ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one cycle's inputs, let the rising edge take them, sample 1 ns later.
  task automatic drive(input logic p_i, input logic en_i, input logic [2:0] mode_i,
                       input logic [7:0] d_i, input logic sl_i, input logic sr_i);
    P     = p_i;
    en    = en_i;
    mode  = mode_i;
    d     = d_i;
    sin_l = sl_i;
    sin_r = sr_i;
    @(posedge clk);
    #1;
    P  = 1'b0;
    en = 1'b0;
  endtask

  task automatic load(input logic [7:0] v);
    drive(1'b0, 1'b1, 3'b001, v, 1'b0, 1'b0);
  endtask

  task automatic test_reset();
    C = 1'b1; P = 1'b0; en = 1'b0; mode = 3'b000; d = 8'h00; sin_l = 1'b0; sin_r = 1'b0;
    #2;
    n_cmp++; if (Q !== 8'h00) begin n_err++; $display("FAIL reset_q: got %h want 00", Q); end
    n_cmp++; if (wrap !== 1'b0) begin n_err++; $display("FAIL reset_wrap: got %b want 0", wrap); end
    n_cmp++; if (zero !== 1'b1) begin n_err++; $display("FAIL reset_zero: got %b want 1", zero); end
    n_cmp++; if ({sout_l, sout_r} !== 2'b00) begin n_err++; $display("FAIL reset_sout: got %b want 00", {sout_l, sout_r}); end
    // Edges while C is held have no effect, even with P or a load requested.
    drive(1'b0, 1'b1, 3'b001, 8'hAA, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 3'b000, 8'h00, 1'b0, 1'b0);
    n_cmp++; if (Q !== 8'h00) begin n_err++; $display("FAIL reset_held_q: got %h want 00", Q); end
    C = 1'b0;
  endtask

  task automatic test_async_clear();
    load(8'hA5);
    n_cmp++; if (Q !== 8'hA5) begin n_err++; $display("FAIL clr_load: got %h want a5", Q); end
    #2 C = 1'b1;
    #1;
    n_cmp++; if (Q !== 8'h00) begin n_err++; $display("FAIL clr_async_q: got %h want 00", Q); end
    n_cmp++; if (zero !== 1'b1) begin n_err++; $display("FAIL clr_async_zero: got %b want 1", zero); end
    #1 C = 1'b0;
    #1;
    n_cmp++; if (Q !== 8'h00) begin n_err++; $display("FAIL clr_release_q: got %h want 00", Q); end
    load(8'h3C);
    n_cmp++; if (Q !== 8'h3C) begin n_err++; $display("FAIL clr_first_edge: got %h want 3c", Q); end
  endtask

  task automatic test_preset();
    load(8'h00);
    drive(1'b0, 1'b1, 3'b111, 8'h00, 1'b0, 1'b0);
    n_cmp++; if ({wrap, Q} !== {1'b1, 8'hFF}) begin n_err++; $display("FAIL pre_setup: got %b/%h want 1/ff", wrap, Q); end
    drive(1'b1, 1'b1, 3'b001, 8'h12, 1'b0, 1'b0);
    n_cmp++; if (Q !== 8'hFF) begin n_err++; $display("FAIL pre_over_en_q: got %h want ff", Q); end
    n_cmp++; if (wrap !== 1'b0) begin n_err++; $display("FAIL pre_over_en_wrap: got %b want 0", wrap); end
    load(8'h34);
    drive(1'b1, 1'b0, 3'b001, 8'h12, 1'b0, 1'b0);
    n_cmp++; if (Q !== 8'hFF) begin n_err++; $display("FAIL pre_no_en_q: got %h want ff", Q); end
  endtask

  task automatic test_shift();
    load(8'h81);
    drive(1'b0, 1'b1, 3'b010, 8'h00, 1'b0, 1'b0);
    n_cmp++; if (Q !== 8'h02) begin n_err++; $display("FAIL shl0_q: got %h want 02", Q); end
    n_cmp++; if (sout_l !== 1'b0) begin n_err++; $display("FAIL shl0_sout_l: got %b want 0", sout_l); end
    drive(1'b0, 1'b1, 3'b011, 8'h00, 1'b0, 1'b1);
    n_cmp++; if (Q !== 8'h81) begin n_err++; $display("FAIL shr1_q: got %h want 81", Q); end
    n_cmp++; if (sout_r !== 1'b1) begin n_err++; $display("FAIL shr1_sout_r: got %b want 1", sout_r); end
    n_cmp++; if (sout_l !== 1'b1) begin n_err++; $display("FAIL shr1_sout_l: got %b want 1", sout_l); end
    drive(1'b0, 1'b1, 3'b010, 8'h00, 1'b1, 1'b0);
    n_cmp++; if (Q !== 8'h03) begin n_err++; $display("FAIL shl1_q: got %h want 03", Q); end
    drive(1'b0, 1'b1, 3'b011, 8'h00, 1'b1, 1'b0);
    n_cmp++; if (Q !== 8'h01) begin n_err++; $display("FAIL shr0_q: got %h want 01", Q); end
  endtask

  task automatic test_rotate();
    load(8'h81);
    drive(1'b0, 1'b1, 3'b100, 8'h00, 1'b0, 1'b0);
    n_cmp++; if (Q !== 8'h03) begin n_err++; $display("FAIL rol_q: got %h want 03", Q); end
    drive(1'b0, 1'b1, 3'b101, 8'h00, 1'b0, 1'b0);
    n_cmp++; if (Q !== 8'h81) begin n_err++; $display("FAIL ror1_q: got %h want 81", Q); end
    drive(1'b0, 1'b1, 3'b101, 8'h00, 1'b0, 1'b0);
    n_cmp++; if (Q !== 8'hC0) begin n_err++; $display("FAIL ror2_q: got %h want c0", Q); end
  endtask

  task automatic test_count_wrap();
    load(8'hFE);
    drive(1'b0, 1'b1, 3'b110, 8'h00, 1'b0, 1'b0);
    n_cmp++; if ({wrap, Q} !== {1'b0, 8'hFF}) begin n_err++; $display("FAIL inc1: got %b/%h want 0/ff", wrap, Q); end
    drive(1'b0, 1'b1, 3'b110, 8'h00, 1'b0, 1'b0);
    n_cmp++; if ({wrap, Q} !== {1'b1, 8'h00}) begin n_err++; $display("FAIL inc2_wrap: got %b/%h want 1/00", wrap, Q); end
    n_cmp++; if (zero !== 1'b1) begin n_err++; $display("FAIL inc2_zero: got %b want 1", zero); end
    drive(1'b0, 1'b1, 3'b110, 8'h00, 1'b0, 1'b0);
    n_cmp++; if ({wrap, Q} !== {1'b0, 8'h01}) begin n_err++; $display("FAIL inc3: got %b/%h want 0/01", wrap, Q); end
    n_cmp++; if (zero !== 1'b0) begin n_err++; $display("FAIL inc3_zero: got %b want 0", zero); end
    drive(1'b0, 1'b1, 3'b111, 8'h00, 1'b0, 1'b0);
    n_cmp++; if ({wrap, Q} !== {1'b0, 8'h00}) begin n_err++; $display("FAIL dec1: got %b/%h want 0/00", wrap, Q); end
    drive(1'b0, 1'b1, 3'b111, 8'h00, 1'b0, 1'b0);
    n_cmp++; if ({wrap, Q} !== {1'b1, 8'hFF}) begin n_err++; $display("FAIL dec2_wrap: got %b/%h want 1/ff", wrap, Q); end
    // Hold mode drops the wrap pulse and keeps Q.
    drive(1'b0, 1'b1, 3'b000, 8'h00, 1'b0, 1'b0);
    n_cmp++; if ({wrap, Q} !== {1'b0, 8'hFF}) begin n_err++; $display("FAIL hold_after_wrap: got %b/%h want 0/ff", wrap, Q); end
    // Disabled edge also drops a pending wrap pulse.
    load(8'hFF);
    drive(1'b0, 1'b1, 3'b110, 8'h00, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 3'b110, 8'h00, 1'b0, 1'b0);
    n_cmp++; if ({wrap, Q} !== {1'b0, 8'h00}) begin n_err++; $display("FAIL dis_after_wrap: got %b/%h want 0/00", wrap, Q); end
  endtask

  task automatic test_enable_gating();
    load(8'h55);
    for (int m = 0; m < 8; m++) begin
      drive(1'b0, 1'b0, m[2:0], 8'hAA, 1'b1, 1'b1);
      n_cmp++;
      if ({wrap, Q} !== {1'b0, 8'h55}) begin
        n_err++;
        $display("FAIL gate_mode%0d: got %b/%h want 0/55", m, wrap, Q);
      end
    end
  endtask

  task automatic test_back_to_back();
    load(8'h0F);
    load(8'hF0);
    n_cmp++; if (Q !== 8'hF0) begin n_err++; $display("FAIL b2b_load: got %h want f0", Q); end
    drive(1'b0, 1'b1, 3'b110, 8'h00, 1'b0, 1'b0);
    drive(1'b0, 1'b1, 3'b100, 8'h00, 1'b0, 1'b0);
    drive(1'b0, 1'b1, 3'b011, 8'h00, 1'b0, 1'b0);
    n_cmp++; if (Q !== 8'h71) begin n_err++; $display("FAIL b2b_chain: got %h want 71", Q); end
  endtask

  initial begin
    test_reset();
    test_async_clear();
    test_preset();
    test_shift();
    test_rotate();
    test_count_wrap();
    test_enable_gating();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
